// File: rtl/hope_uart_rx_pkg.sv
// hope_pkg: shared types and constants for the hope UART receive front-end.
// Optional feature macro: HOPE_UART_PARITY_EN (adds the PARITY state, 8E1 framing).
package hope_pkg;

    // 50 MHz system clock divided by 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    // Receive FSM states; PARITY only exists when parity checking is built in
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef HOPE_UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_t;

    // Width of a counter that runs from 0 to clks-1
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/hope_uart_rx_if.sv
// hope_uart_rx_if: one-entry byte output channel with valid/ready handshake.
// The receiver drives data/valid through the master modport; the consumer
// drives ready through the slave modport.
interface hope_uart_rx_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/hope_uart_rx_sync2.sv
// hope_sync2: generic two-flop synchroniser for a single asynchronous bit.
// RESET_VAL sets the value both flops take during reset, so an idle-high line
// does not look like a start bit when reset is released.
module hope_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hope_uart_rx.sv
// hope_uart_rx: UART receive front-end. Synchronises the serial line, finds the
// start bit, samples each bit mid-cell, checks framing and hands the byte out
// through a one-entry valid/ready register with sticky error flags.
// Optional feature macro: HOPE_UART_PARITY_EN (8E1 with parity check; default 8N1).
module hope_uart_rx
    import hope_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           rx,
    input  logic           err_clr,
    output logic           frame_err,
    output logic           overrun,
    output logic           parity_err,
    hope_uart_rx_if.master out_if
);

    localparam int            CW        = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic           rx_s;
    uart_rx_state_t state;
    uart_rx_state_t state_next;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           baud_tick;
    logic           counting;
    logic           shift_en;
    logic           deliver;
    logic           set_frame;
    logic           set_overrun;
    logic           clr_bits;
    logic           parity_hold;
`ifdef HOPE_UART_PARITY_EN
    logic           set_parity;
`endif

    hope_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    // Baud tick: half a bit in START to reach mid-cell, a full bit thereafter
    always_comb begin
        baud_tick = 1'b0;
        counting  = 1'b0;
        case (state)
            ST_START: begin
                counting  = 1'b1;
                baud_tick = (baud_cnt == HALF_LAST);
            end
            ST_DATA,
`ifdef HOPE_UART_PARITY_EN
            ST_PARITY,
`endif
            ST_STOP: begin
                counting  = 1'b1;
                baud_tick = (baud_cnt == FULL_LAST);
            end
            default: begin
                counting  = 1'b0;
                baud_tick = 1'b0;
            end
        endcase
    end

    // Next-state and per-cycle action decode; ena low forces IDLE with no side effects
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        set_frame  = 1'b0;
        clr_bits   = 1'b0;
`ifdef HOPE_UART_PARITY_EN
        set_parity = 1'b0;
`endif
        if (!ena) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_next = ST_START;
                        clr_bits   = 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state_next = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef HOPE_UART_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end
                    end
                end
`ifdef HOPE_UART_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        set_parity = (rx_s != (^shift_reg));
                        state_next = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        if (rx_s) begin
                            deliver    = !parity_hold;
                            state_next = ST_IDLE;
                        end else begin
                            set_frame  = 1'b1;
                            state_next = ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Baud counter restarts on every state change, every tick and whenever ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (!ena || !counting || baud_tick || (state_next != state)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Bit counter and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (clr_bits) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
            end
        end
    end

`ifdef HOPE_UART_PARITY_EN
    // Remembers a parity mismatch for the current frame so STOP discards the byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_hold <= 1'b0;
        end else if (clr_bits) begin
            parity_hold <= 1'b0;
        end else if (set_parity) begin
            parity_hold <= 1'b1;
        end
    end
`else
    assign parity_hold = 1'b0;
`endif

    assign set_overrun = deliver && out_if.out_valid && !out_if.out_ready;

    // One-entry output register: load when empty or being drained this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_if.out_data  <= 8'h00;
            out_if.out_valid <= 1'b0;
        end else if (deliver && (!out_if.out_valid || out_if.out_ready)) begin
            out_if.out_data  <= shift_reg;
            out_if.out_valid <= 1'b1;
        end else if (out_if.out_valid && out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event in the same cycle beats err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (set_frame) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef HOPE_UART_PARITY_EN
    // Sticky parity flag, same set-wins rule as the other flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (set_parity) begin
            parity_err <= 1'b1;
        end else if (err_clr) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_hope_uart_rx.sv
// tb_hope_uart_rx: scoreboard bench for hope_uart_rx with CLKS_PER_BIT = 8.
// Expected bytes are queued when a frame is sent and popped by a monitor on
// every accepted handshake. Honours HOPE_UART_PARITY_EN when defined.
module tb_hope_uart_rx;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic rx;
    logic err_clr;
    logic frame_err;
    logic overrun;
    logic parity_err;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];

    hope_uart_rx_if bus ();

    hope_uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx        (rx),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err),
        .out_if    (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted byte must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_byte: got 0x%02h, required no delivery", bus.out_data);
            end else begin
                logic [7:0] want;
                want = exp_q.pop_front();
                if (bus.out_data !== want) begin
                    mismatched++;
                    $display("[TB] FAIL byte_data: got 0x%02h, required 0x%02h", bus.out_data, want);
                end
            end
        end
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        step(CPB);
    endtask

    // Full frame with correct parity (parity build) and a chosen stop level
    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef HOPE_UART_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_v);
        rx = 1'b1;
    endtask

`ifdef HOPE_UART_PARITY_EN
    // Frame with an explicitly chosen parity bit
    task automatic send_frame_par(input logic [7:0] d, input logic par_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par_v);
        send_bit(1'b1);
    endtask
`endif

    // Waits for the scoreboard queue to empty, bounded by a cycle budget
    task automatic wait_drain(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (exp_q.size() == 0) ok = 1'b1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; rx = 1'b1; err_clr = 1'b0; bus.out_ready = 1'b1;
        step(3);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b, required 0", bus.out_valid); end
        compared++;
        if (bus.out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data: got 0x%02h, required 0x00", bus.out_data); end
        compared++;
        if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_err: got %b, required 0", frame_err); end
        compared++;
        if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %b, required 0", overrun); end
        compared++;
        if (parity_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_parity_err: got %b, required 0", parity_err); end
        rst_n = 1'b1;
        step(4);
    endtask

    task automatic test_basic();
        logic ok;
        bus.out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain(4 * CPB, ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_delivery: got pending=%0d, required 0", exp_q.size()); end
        step(2);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_valid_drop: got %b, required 0", bus.out_valid); end
        compared++;
        if ({frame_err, overrun, parity_err} !== 3'b000) begin
            mismatched++; $display("[TB] FAIL basic_flags: got %b, required 000", {frame_err, overrun, parity_err});
        end
    endtask

    task automatic test_overrun();
        logic ok;
        bus.out_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        step(CPB);
        compared++;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_valid_held: got %b, required 1", bus.out_valid); end
        compared++;
        if (bus.out_data !== 8'h3C) begin mismatched++; $display("[TB] FAIL ovr_data_held: got 0x%02h, required 0x3C", bus.out_data); end
        compared++;
        if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_flag_set: got %b, required 1", overrun); end
        pulse_clr();
        compared++;
        if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL ovr_flag_clr: got %b, required 0", overrun); end
        bus.out_ready = 1'b1;
        wait_drain(4 * CPB, ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_drain: got pending=%0d, required 0", exp_q.size()); end
        step(2);
    endtask

    task automatic test_frame_err();
        logic ok;
        bus.out_ready = 1'b1;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        step(40);
        rx = 1'b1;
        step(2 * CPB);
        compared++;
        if (frame_err !== 1'b1) begin mismatched++; $display("[TB] FAIL ferr_set: got %b, required 1", frame_err); end
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ferr_no_delivery: got %b, required 0", bus.out_valid); end
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_drain(4 * CPB, ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL ferr_recover: got pending=%0d, required 0", exp_q.size()); end
        pulse_clr();
        compared++;
        if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL ferr_clr: got %b, required 0", frame_err); end
    endtask

    task automatic test_glitch();
        bus.out_ready = 1'b1;
        rx = 1'b0;
        step(2);
        rx = 1'b1;
        step(4 * CPB);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_valid: got %b, required 0", bus.out_valid); end
        compared++;
        if ({frame_err, overrun, parity_err} !== 3'b000) begin
            mismatched++; $display("[TB] FAIL glitch_flags: got %b, required 000", {frame_err, overrun, parity_err});
        end
    endtask

    task automatic test_ena_abort();
        logic ok;
        bus.out_ready = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        step(3);
        ena = 1'b0;
        step(2);
        ena = 1'b1;
        step(12 * CPB);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ena_abort_valid: got %b, required 0", bus.out_valid); end
        compared++;
        if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL ena_abort_ferr: got %b, required 0", frame_err); end
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        wait_drain(4 * CPB, ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL ena_recover: got pending=%0d, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        bus.out_ready = 1'b1;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        send_frame(8'h5A, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_drain(4 * CPB, ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_drain: got pending=%0d, required 0", exp_q.size()); end
        compared++;
        if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_overrun: got %b, required 0", overrun); end
    endtask

    task automatic test_parity();
`ifdef HOPE_UART_PARITY_EN
        logic ok;
        bus.out_ready = 1'b1;
        send_frame_par(8'h07, 1'b0);
        step(CPB);
        compared++;
        if (parity_err !== 1'b1) begin mismatched++; $display("[TB] FAIL par_err_set: got %b, required 1", parity_err); end
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL par_discard: got %b, required 0", bus.out_valid); end
        pulse_clr();
        compared++;
        if (parity_err !== 1'b0) begin mismatched++; $display("[TB] FAIL par_err_clr: got %b, required 0", parity_err); end
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        wait_drain(4 * CPB, ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL par_good_delivery: got pending=%0d, required 0", exp_q.size()); end
`else
        step(1);
        compared++;
        if (parity_err !== 1'b0) begin mismatched++; $display("[TB] FAIL par_tied_low: got %b, required 0", parity_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_ena_abort();
        test_back_to_back();
        test_parity();
        step(4 * CPB);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++; $display("[TB] FAIL final_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
